// File: rtl/spi_rtl_pkg.sv
// Shared FSM state, mode type and default sizing for the SPI master serial engine.
// Pure declarations; no timing or flow-control behaviour of its own.
package spi_rtl_pkg;

    localparam int SPI_DATA_WIDTH_DEF    = 8;
    localparam int SPI_CLK_DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_HOLD     = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock sequencer: one tick per H = clk_div+1 pclk cycles while active, sclk toggles on ticks 1..2*DATA_WIDTH.
// Strobes are decoded from registered counters in the tick cycle; sclk is registered. No backpressure.
module spi_sclk_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_active,
    input  logic                     i_idle_cpol,
    input  logic                     i_cpol,
    input  logic [CLK_DIV_WIDTH-1:0] i_clk_div,
    output logic                     o_tick,
    output logic                     o_lead_stb,
    output logic                     o_trail_stb,
    output logic                     o_last_edge,
    output logic                     o_sclk
);

    localparam int EW = $clog2(2*DATA_WIDTH + 2);
    localparam logic [EW-1:0]            E_LAST  = EW'(2*DATA_WIDTH - 1);
    localparam logic [EW-1:0]            E_EDGES = EW'(2*DATA_WIDTH);
    localparam logic [EW-1:0]            E_ONE   = EW'(1);
    localparam logic [CLK_DIV_WIDTH-1:0] H_ONE   = CLK_DIV_WIDTH'(1);

    logic [CLK_DIV_WIDTH-1:0] r_hcnt;
    logic [EW-1:0]            r_ecnt;
    logic                     r_sclk;
    logic                     w_tick;
    logic                     w_edge;

    // Tick 1 ends SETUP and is edge 1; tick 2*DATA_WIDTH+1 ends HOLD.
    assign w_tick      = i_active && (r_hcnt == i_clk_div);
    assign w_edge      = w_tick && (r_ecnt < E_EDGES);
    assign o_tick      = w_tick;
    assign o_lead_stb  = w_edge && !r_ecnt[0];
    assign o_trail_stb = w_edge && r_ecnt[0];
    assign o_last_edge = w_tick && (r_ecnt == E_LAST);
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_ecnt <= '0;
            r_sclk <= 1'b0;
        end else if (!i_active) begin
            r_hcnt <= '0;
            r_ecnt <= '0;
            r_sclk <= i_idle_cpol;
        end else begin
            r_hcnt <= w_tick ? '0 : r_hcnt + H_ONE;
            if (w_tick) begin
                r_ecnt <= r_ecnt + E_ONE;
            end
            if (w_edge) begin
                r_sclk <= ~r_sclk;
            end else if (r_ecnt == '0) begin
                r_sclk <= i_cpol;
            end
        end
    end

endmodule

// File: rtl/spi_master_shift_engine.sv
// SPI master engine: latches word+mode on start, shifts mosi0/captures miso0, pulses done with rx_data.
// cs falls 1 cycle after start, done at 1+(2*DATA_WIDTH+1)*H; start while busy is dropped, never queued.
module spi_master_shift_engine
    import spi_rtl_pkg::*;
#(
    parameter int DATA_WIDTH    = SPI_DATA_WIDTH_DEF,
    parameter int CLK_DIV_WIDTH = SPI_CLK_DIV_WIDTH_DEF
) (
    input  logic                     pclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic                     lsb_first,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic [DATA_WIDTH-1:0]    tx_data,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     busy,
    output logic                     done,
    output logic                     sclk,
    output logic                     cs,
    output logic                     mosi0,
    input  logic                     miso0
);

    spi_state_e               r_state;
    spi_mode_t                r_mode;
    logic                     r_lsb;
    logic [CLK_DIV_WIDTH-1:0] r_div;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    r_rx;
    logic                     r_sbit;
    logic                     r_mosi;
    logic                     r_cs;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_active;
    logic                     w_tick;
    logic                     w_lead;
    logic                     w_trail;
    logic                     w_last;
    logic                     w_sclk;
    logic                     w_rx_bit;
    logic                     w_out_bit;
    logic                     w_next_bit;
    logic                     w_first_bit;
    logic [DATA_WIDTH-1:0]    w_shifted;

    assign w_active = (r_state != ST_IDLE);

    spi_sclk_gen #(
        .DATA_WIDTH    (DATA_WIDTH),
        .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
    ) u_sclk_gen (
        .clk         (pclk),
        .rst         (areset),
        .i_active    (w_active),
        .i_idle_cpol (cpol),
        .i_cpol      (r_mode.cpol),
        .i_clk_div   (r_div),
        .o_tick      (w_tick),
        .o_lead_stb  (w_lead),
        .o_trail_stb (w_trail),
        .o_last_edge (w_last),
        .o_sclk      (w_sclk)
    );

    // One shift register carries both directions: tx leaves one end while rx enters the other.
    assign w_rx_bit    = r_mode.cpha ? miso0 : r_sbit;
    assign w_shifted   = r_lsb ? {w_rx_bit, r_shift[DATA_WIDTH-1:1]}
                               : {r_shift[DATA_WIDTH-2:0], w_rx_bit};
    assign w_out_bit   = r_lsb ? r_shift[0] : r_shift[DATA_WIDTH-1];
    assign w_next_bit  = r_lsb ? r_shift[1] : r_shift[DATA_WIDTH-2];
    assign w_first_bit = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_lsb   <= 1'b0;
            r_div   <= '0;
            r_shift <= '0;
            r_rx    <= '0;
            r_sbit  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode.cpol <= cpol;
                        r_mode.cpha <= cpha;
                        r_lsb       <= lsb_first;
                        r_div       <= clk_div;
                        r_shift     <= tx_data;
                        if (!cpha) begin
                            r_mosi <= w_first_bit;
                        end
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_TRANSFER;
                    end
                end
                ST_TRANSFER: begin
                    if (w_last) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rx    <= r_shift;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_lead) begin
                if (r_mode.cpha) begin
                    r_mosi <= w_out_bit;
                end else begin
                    r_sbit <= miso0;
                end
            end
            // The final trailing edge only captures; mosi0 keeps the last bit.
            if (w_trail) begin
                r_shift <= w_shifted;
                if (!r_mode.cpha && !w_last) begin
                    r_mosi <= w_next_bit;
                end
            end
        end
    end

    assign rx_data = r_rx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sclk    = w_sclk;
    assign cs      = r_cs;
    assign mosi0   = r_mosi;

endmodule

// File: tb/tb_spi_master_shift_engine.sv
// Bench for spi_master_shift_engine: SPI slave model plus scoreboard queues checked on every done pulse.
module tb_spi_master_shift_engine;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          pclk = 1'b0;
    logic          areset;
    logic          start;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [CW-1:0] clk_div;
    logic [W-1:0]  tx_data;
    logic [W-1:0]  rx_data;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          cs;
    logic          mosi0;
    logic          miso0;

    always #5 pclk = ~pclk;

    spi_master_shift_engine #(
        .DATA_WIDTH    (W),
        .CLK_DIV_WIDTH (CW)
    ) dut (
        .pclk      (pclk),
        .areset    (areset),
        .start     (start),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .sclk      (sclk),
        .cs        (cs),
        .mosi0     (mosi0),
        .miso0     (miso0)
    );

    int total     = 0;
    int bad       = 0;
    int n_done    = 0;
    int exp_dones = 0;

    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_tx_q[$];
    logic [W-1:0] slave_q[$];

    bit           loopback  = 1'b0;
    logic         s_miso    = 1'b0;
    logic [W-1:0] s_word    = '0;
    logic [W-1:0] s_cap     = '0;
    int           s_idx     = 0;
    int           s_viol    = 0;
    logic         prev_cs   = 1'b1;
    logic         prev_sclk = 1'b0;
    logic         prev_mosi = 1'b0;

    assign miso0 = loopback ? mosi0 : s_miso;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bpos(input int i);
        return lsb_first ? i : (W - 1 - i);
    endfunction

    // Slave: drives miso0 and captures mosi0 on the SPI edges implied by the current mode.
    initial begin : slave
        logic lead;
        forever begin
            @(posedge pclk);
            #1;
            if (prev_cs && !cs) begin
                s_idx = 0;
                s_cap = '0;
                s_word = '0;
                if (slave_q.size() > 0) s_word = slave_q.pop_front();
                if (!cpha) s_miso = s_word[bpos(0)];
            end else if (!cs && (sclk !== prev_sclk)) begin
                lead = (sclk !== cpol);
                if (lead ^ cpha) begin
                    if (mosi0 !== prev_mosi) s_viol++;
                    if (s_idx < W) s_cap[bpos(s_idx)] = mosi0;
                    if (cpha) s_idx++;
                end else begin
                    if (!cpha) s_idx++;
                    if (s_idx < W) s_miso = s_word[bpos(s_idx)];
                end
            end
            prev_cs   = cs;
            prev_sclk = sclk;
            prev_mosi = mosi0;
        end
    end

    initial begin : monitor
        logic [W-1:0] e_rx;
        logic [W-1:0] e_tx;
        forever begin
            @(posedge pclk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                check_eq("sb_pending", 32'(exp_rx_q.size() > 0), 32'd1);
                if (exp_rx_q.size() > 0) begin
                    e_rx = exp_rx_q.pop_front();
                    e_tx = exp_tx_q.pop_front();
                    check_eq("rx_data", 32'(rx_data), 32'(e_rx));
                    check_eq("mosi_word", 32'(s_cap), 32'(e_tx));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic xfer(input logic pol, input logic pha, input logic lsb, input logic [CW-1:0] div,
                        input logic [W-1:0] tx, input logic [W-1:0] sw, input bit loop,
                        input bit poke, input string tag);
        int h;
        int n;
        int cs_low;
        int first_edge;
        int done_at;
        h = int'(div) + 1;
        cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; tx_data = tx; loopback = loop;
        repeat (2) @(negedge pclk);
        check_eq({tag, "_idle_sclk"}, 32'(sclk), 32'(pol));
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        exp_rx_q.push_back(loop ? tx : sw);
        exp_tx_q.push_back(tx);
        slave_q.push_back(sw);
        exp_dones++;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        n = 1; cs_low = 0; first_edge = 0; done_at = 0;
        while (done_at == 0 && n < 4000) begin
            if (!cs) cs_low++;
            if (first_edge == 0 && sclk !== pol) first_edge = n;
            if (done) begin
                done_at = n;
            end else begin
                if (poke) begin
                    start = (n == 3 || n == 10);
                    if (n == 5) tx_data = ~tx;
                end
                @(negedge pclk);
                n++;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_cyc"}, 32'(done_at), 32'(1 + (2*W + 1)*h));
        check_eq({tag, "_cs_low"}, 32'(cs_low), 32'((2*W + 1)*h));
        check_eq({tag, "_first_edge"}, 32'(first_edge), 32'(1 + h));
    endtask

    initial begin : main
        int d0;
        int n;
        int dcnt;
        int gap;
        bit in_gap;
        areset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = '0; tx_data = '0;
        repeat (2) @(negedge pclk);
        check_eq("rst_cs", 32'(cs), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi0), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rx", 32'(rx_data), 32'd0);
        areset = 1'b0;
        @(negedge pclk);

        xfer(1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 8'h3C, 1'b0, 1'b0, "mode0");
        xfer(1'b1, 1'b1, 1'b1, 8'd3, 8'h81, 8'h7E, 1'b0, 1'b0, "mode3");
        xfer(1'b0, 1'b1, 1'b0, 8'd1, 8'hC3, 8'h00, 1'b1, 1'b0, "mode1_loop");
        xfer(1'b1, 1'b0, 1'b0, 8'd2, 8'hC3, 8'h00, 1'b1, 1'b0, "mode2_loop");

        xfer(1'b0, 1'b0, 1'b0, 8'd1, 8'h5A, 8'h96, 1'b0, 1'b1, "ignore_start");
        d0 = n_done;
        repeat (40) @(negedge pclk);
        check_eq("ignore_no_extra_done", 32'(n_done), 32'(d0));
        check_eq("ignore_cs_idle", 32'(cs), 32'd1);

        // Abort a mode 2 transfer with areset at cycle 7.
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; tx_data = 8'hF0; loopback = 1'b0;
        repeat (2) @(negedge pclk);
        exp_rx_q.push_back(8'h0F);
        exp_tx_q.push_back(8'hF0);
        slave_q.push_back(8'h0F);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        repeat (6) @(negedge pclk);
        check_eq("pre_rst_cs", 32'(cs), 32'd0);
        d0 = n_done;
        areset = 1'b1;
        #1;
        check_eq("arst_cs", 32'(cs), 32'd1);
        check_eq("arst_sclk", 32'(sclk), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_rx", 32'(rx_data), 32'd0);
        exp_rx_q.delete();
        exp_tx_q.delete();
        slave_q.delete();
        repeat (3) @(negedge pclk);
        areset = 1'b0;
        repeat (3) @(negedge pclk);
        check_eq("arst_no_done", 32'(n_done), 32'(d0));

        xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'h3A, 8'h65, 1'b0, 1'b0, "post_rst");

        // Back-to-back with start held high; second word latched at the second start.
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; tx_data = 8'h69; loopback = 1'b0;
        repeat (2) @(negedge pclk);
        exp_rx_q.push_back(8'h17); exp_tx_q.push_back(8'h69); slave_q.push_back(8'h17);
        exp_rx_q.push_back(8'hE8); exp_tx_q.push_back(8'h96); slave_q.push_back(8'hE8);
        exp_dones += 2;
        start = 1'b1;
        @(negedge pclk);
        tx_data = 8'h96;
        n = 1; dcnt = 0; gap = 0; in_gap = 1'b0;
        while (dcnt < 2 && n < 4000) begin
            if (done) begin
                dcnt++;
                if (dcnt == 1) in_gap = 1'b1;
            end
            if (in_gap) begin
                if (cs) begin
                    gap++;
                end else begin
                    in_gap = 1'b0;
                    start = 1'b0;
                end
            end
            @(negedge pclk);
            n++;
        end
        start = 1'b0;
        check_eq("b2b_dones", 32'(dcnt), 32'd2);
        check_eq("b2b_cs_gap", 32'(gap), 32'd1);

        repeat (5) @(negedge pclk);
        check_eq("all_dones", 32'(n_done), 32'(exp_dones));
        check_eq("sb_drained", 32'(exp_rx_q.size()), 32'd0);
        check_eq("mosi_stable_at_sample", 32'(s_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
